kv10_shifter: RTL and testbench



---
 rtl/kv10_shifter.sv | 174 +++++++++++++++++
 tb/tb_kv10_shifter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv10_shifter.sv
// kv10_shifter: multi-cycle PDP-10 shift/rotate unit (LSH, ROT, ASH, LSHC, ROTC, ASHC).
// A signed count selects direction and magnitude. Each RUN cycle moves at most STEP positions.
// Build option: define KV10_SHIFT_ABORT_EN to add an `abort` input that cancels a running op.
module kv10_shifter #(
    parameter int WIDTH = 36,
    parameter int STEP  = 8,
    parameter int CNTW  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef KV10_SHIFT_ABORT_EN
    input  logic             abort,
`endif
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Alow,
    input  logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultlow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int DW = 2 * WIDTH;      // doubleword width
    localparam int MW = 2 * WIDTH - 2;  // ASHC magnitude width
    localparam logic [CNTW-1:0] STEP_C = CNTW'(STEP);

    localparam logic [2:0] CMD_LSH  = 3'd0;
    localparam logic [2:0] CMD_ROT  = 3'd1;
    localparam logic [2:0] CMD_ASH  = 3'd2;
    localparam logic [2:0] CMD_LSHC = 3'd4;
    localparam logic [2:0] CMD_ROTC = 3'd5;
    localparam logic [2:0] CMD_ASHC = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       op;         // latched command
    logic             left;       // latched direction: 1 = left
    logic [CNTW-1:0]  rem;        // positions still to shift
    logic [CNTW-1:0]  mag;        // |count|, unsigned so the most negative count is representable
    logic [CNTW-1:0]  s;          // positions moved this cycle
    logic [WIDTH-1:0] hi, lo;     // working high/low words, also the visible results
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             ovf, ovf_step;
    logic             sign;
    logic             accept, op_valid, abort_run;
    logic [DW-1:0]    rot_w;      // {hi,hi} shifted: a window of it is the single-word rotate
    logic [2*DW-1:0]  rot_d;      // {hi,lo,hi,lo} shifted: a window of it is the doubleword rotate
    logic [MW-1:0]    ashc_m0, ashc_m;

    assign mag      = count[CNTW-1] ? -count : count;
    assign op_valid = (command[1:0] != 2'b11);
    assign accept   = start && (state != RUN);
    assign s        = (rem < STEP_C) ? rem : STEP_C;
    assign sign     = hi[WIDTH-1];

`ifdef KV10_SHIFT_ABORT_EN
    assign abort_run = abort && (state == RUN);
`else
    assign abort_run = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (mag != '0 && op_valid) ? RUN : DONE;
            end
            RUN: begin
                busy = 1'b1;
                if (abort_run)          state_nxt = IDLE;
                else if (rem <= STEP_C) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = (mag != '0 && op_valid) ? RUN : DONE;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One step of the latched shift by s positions, plus overflow from bits leaving the magnitude.
    always_comb begin
        hi_nxt   = hi;
        lo_nxt   = lo;
        ovf_step = 1'b0;
        rot_w    = left ? ({hi, hi} << s) : ({hi, hi} >> s);
        rot_d    = left ? ({hi, lo, hi, lo} << s) : ({hi, lo, hi, lo} >> s);
        ashc_m0  = {hi[WIDTH-2:0], lo[WIDTH-2:0]};
        ashc_m   = left ? (ashc_m0 << s) : MW'($signed({sign, ashc_m0}) >>> s);
        case (op)
            CMD_LSH:  hi_nxt = left ? (hi << s) : (hi >> s);
            CMD_ROT:  hi_nxt = left ? rot_w[DW-1:WIDTH] : rot_w[WIDTH-1:0];
            CMD_ASH: begin
                if (left) begin
                    hi_nxt = {sign, hi[WIDTH-2:0] << s};
                    // Top s bits of {magnitude, zero fill}, each compared against the sign.
                    ovf_step = (({hi[WIDTH-2:0] ^ {(WIDTH-1){sign}}, {STEP{sign}}})
                                >> (WIDTH - 1 + STEP - int'(s))) != '0;
                end else begin
                    hi_nxt = $signed(hi) >>> s;
                end
            end
            CMD_LSHC: {hi_nxt, lo_nxt} = left ? ({hi, lo} << s) : ({hi, lo} >> s);
            CMD_ROTC: {hi_nxt, lo_nxt} = left ? rot_d[2*DW-1:DW] : rot_d[DW-1:0];
            CMD_ASHC: begin
                hi_nxt = {sign, ashc_m[MW-1:WIDTH-1]};
                lo_nxt = {sign, ashc_m[WIDTH-2:0]};
                if (left) begin
                    ovf_step = (({ashc_m0 ^ {MW{sign}}, {STEP{sign}}})
                                >> (MW + STEP - int'(s))) != '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath: load operands on accept, step while running, clear on reset or abort.
    // NOTE: the working words are reset as well, because they drive result/resultlow directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            ovf  <= 1'b0;
            rem  <= '0;
            op   <= '0;
            left <= 1'b0;
        end else if (abort_run) begin
            hi  <= '0;
            lo  <= '0;
            ovf <= 1'b0;
            rem <= '0;
        end else if (accept) begin
            hi   <= A;
            lo   <= Alow;
            ovf  <= 1'b0;
            op   <= command;
            left <= ~count[CNTW-1];
            rem  <= mag;
        end else if (state == RUN) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            ovf <= ovf | ovf_step;
            rem <= rem - s;
        end
    end

    assign result    = hi;
    assign resultlow = lo;
    assign overflow  = ovf;

endmodule

// File: tb/tb_kv10_shifter.sv
// Scoreboard bench for kv10_shifter: stimulus pushes expected outcomes, a monitor pops on done.
// Also runs with KV10_SHIFT_ABORT_EN defined, adding the abort scenario.
module tb_kv10_shifter;

    localparam int WIDTH = 36;
    localparam int CNTW  = 9;

    localparam logic [2:0] LSH  = 3'd0;
    localparam logic [2:0] ROT  = 3'd1;
    localparam logic [2:0] ASH  = 3'd2;
    localparam logic [2:0] LSHC = 3'd4;
    localparam logic [2:0] ROTC = 3'd5;
    localparam logic [2:0] ASHC = 3'd6;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        string name;
        word_t r;
        word_t rl;
        logic  ov;
        int    k;          // cycle (after the accepting edge) in which done must be high
        int    start_cyc;  // number of the accepting edge
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      command;
    word_t           A, Alow;
    logic [CNTW-1:0] count;
    word_t           result, resultlow;
    logic            overflow, busy, done;
`ifdef KV10_SHIFT_ABORT_EN
    logic            abort;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    kv10_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef KV10_SHIFT_ABORT_EN
        .abort     (abort),
`endif
        .command   (command),
        .A         (A),
        .Alow      (Alow),
        .count     (count),
        .result    (result),
        .resultlow (resultlow),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    // Holds start for one cycle from the current negedge, then scrambles the operands.
    task automatic drive(input logic [2:0] cmd, input word_t a, input word_t al, input int cnt);
        start   = 1'b1;
        command = cmd;
        A       = a;
        Alow    = al;
        count   = cnt[CNTW-1:0];
        @(negedge clk);
        start   = 1'b0;
        command = ASHC;
        A       = 36'o707070_707070;
        Alow    = 36'o070707_070707;
        count   = 9'h0ff;
    endtask

    task automatic issue(input string name, input logic [2:0] cmd, input word_t a, input word_t al,
                         input int cnt, input word_t r, input word_t rl, input logic ov, input int k);
        sb.push_back('{name, r, rl, ov, k, cyc + 1});
        drive(cmd, a, al, cnt);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d op(s) pending after %0d cycles, expected 0", name, sb.size(), n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: counts busy cycles and checks each done against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (busy || done) check("busy_done_exclusive", 72'(busy && done), 72'(0));
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"},      72'(result),    72'(e.r));
                    check({e.name, "_resultlow"},   72'(resultlow), 72'(e.rl));
                    check({e.name, "_overflow"},    72'(overflow),  72'(e.ov));
                    check({e.name, "_latency"},     72'(cyc - e.start_cyc + 1), 72'(e.k));
                    check({e.name, "_busy_cycles"}, 72'(busy_run),  72'(e.k - 1));
                end
                busy_run = 0;
            end
            if (reset) busy_run = 0;
`ifdef KV10_SHIFT_ABORT_EN
            if (abort) busy_run = 0;
`endif
        end
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int n;
        reset   = 1'b1;
        start   = 1'b0;
        command = LSH;
        A       = '0;
        Alow    = '0;
        count   = '0;
`ifdef KV10_SHIFT_ABORT_EN
        abort   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_result",    72'(result),    72'(0));
        check("reset_resultlow", 72'(resultlow), 72'(0));
        check("reset_overflow",  72'(overflow),  72'(0));
        check("reset_busy",      72'(busy),      72'(0));
        check("reset_done",      72'(done),      72'(0));
        reset = 1'b0;
        @(negedge clk);

        issue("lsh_2", LSH, 36'o000004_000000, 36'o123456_701234, 2,
              36'o000020_000000, 36'o123456_701234, 1'b0, 2);
        wait_idle("lsh_2");
        issue("rotc_m2", ROTC, 36'o0, 36'o000000_000001, -2,
              36'o200000_000000, 36'o0, 1'b0, 2);
        wait_idle("rotc_m2");
        issue("ash_ovf", ASH, 36'o377777_777777, 36'o555, 1,
              36'o377777_777776, 36'o555, 1'b1, 2);
        wait_idle("ash_ovf");
        issue("ash_m3", ASH, 36'o777777_777770, 36'o0, -3,
              36'o777777_777777, 36'o0, 1'b0, 2);
        wait_idle("ash_m3");

        // ROT by a full word, a start while busy, and a back-to-back start in the DONE cycle.
        issue("rot_36", ROT, 36'o000000_000001, 36'o777, 36,
              36'o000000_000001, 36'o777, 1'b0, 6);
        n = cyc;
        @(negedge clk);
        drive(LSH, 36'o777777_777777, 36'o0, 1);
        wait_cyc(n + 5);
        issue("lshc_40_b2b", LSHC, 36'o0, 36'o000000_000001, 40,
              36'o000000_000020, 36'o0, 1'b0, 6);
        wait_idle("lshc_40_b2b");

        issue("count_0", LSH, 36'o555555_555555, 36'o111, 0,
              36'o555555_555555, 36'o111, 1'b0, 1);
        wait_idle("count_0");
        issue("reserved_3", 3'd3, 36'o123123_123123, 36'o321, 5,
              36'o123123_123123, 36'o321, 1'b0, 1);
        wait_idle("reserved_3");

        issue("ashc_l1", ASHC, 36'o0, 36'o400000_000001, 1,
              36'o0, 36'o000000_000002, 1'b0, 2);
        wait_idle("ashc_l1");
        issue("ashc_r1", ASHC, 36'o400000_000000, 36'o0, -1,
              36'o600000_000000, 36'o400000_000000, 1'b0, 2);
        wait_idle("ashc_r1");
        issue("ashc_ovf", ASHC, 36'o200000_000000, 36'o0, 1,
              36'o0, 36'o0, 1'b1, 2);
        wait_idle("ashc_ovf");
        issue("lsh_m36", LSH, 36'o777777_777777, 36'o42, -36,
              36'o0, 36'o42, 1'b0, 6);
        wait_idle("lsh_m36");
        issue("ash_35_ovf", ASH, 36'o000000_000001, 36'o7, 35,
              36'o0, 36'o7, 1'b1, 6);
        wait_idle("ash_35_ovf");
        issue("rotc_m256", ROTC, 36'o000000_000001, 36'o0, -256,
              36'o040000_000000, 36'o0, 1'b0, 33);
        wait_idle("rotc_m256");
        repeat (3) @(negedge clk);
        check("hold_result",    72'(result),    72'(36'o040000_000000));
        check("hold_resultlow", 72'(resultlow), 72'(0));

        // Reset during the third RUN cycle of a long rotate: op abandoned, no done.
        n = cyc + 1;
        drive(ROT, 36'o123456_765432, 36'o000000_000001, -200);
        wait_cyc(n + 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_result",    72'(result),    72'(0));
        check("midreset_resultlow", 72'(resultlow), 72'(0));
        check("midreset_overflow",  72'(overflow),  72'(0));
        check("midreset_busy",      72'(busy),      72'(0));
        check("midreset_done",      72'(done),      72'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midreset_idle_busy", 72'(busy), 72'(0));
        issue("post_reset_lsh", LSH, 36'o000000_000001, 36'o3, 1,
              36'o000000_000002, 36'o3, 1'b0, 2);
        wait_idle("post_reset_lsh");

`ifdef KV10_SHIFT_ABORT_EN
        n = cyc + 1;
        drive(ROT, 36'o123456_765432, 36'o000000_000001, -200);
        wait_cyc(n + 2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_result",    72'(result),    72'(0));
        check("abort_resultlow", 72'(resultlow), 72'(0));
        check("abort_overflow",  72'(overflow),  72'(0));
        check("abort_busy",      72'(busy),      72'(0));
        check("abort_done",      72'(done),      72'(0));
        @(negedge clk);
        abort = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_idle_busy", 72'(busy), 72'(0));
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
